// File: rtl/otbn_pq_pkg.sv
// Shared types for the Montgomery form converter: FSM states and conversion direction.
package otbn_pq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } conv_state_e;

    typedef enum logic {
        TO_MONT   = 1'b0,
        FROM_MONT = 1'b1
    } conv_dir_e;

endpackage

// File: rtl/mont_conv_step.sv
// One bit-serial Montgomery conversion iteration: modular doubling (to form)
// or halving modulo q (from form), selected by direction.
module mont_conv_step
    import otbn_pq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  conv_dir_e             dir_i,
    input  logic [DATA_WIDTH:0]   acc_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic [DATA_WIDTH:0]   acc_o
);

    logic [DATA_WIDTH:0] q_ext;
    logic [DATA_WIDTH:0] dbl;
    logic [DATA_WIDTH:0] sum;

    always_comb begin
        q_ext = {1'b0, q_i};
        // acc < q < 2^(W-1), so the doubled value and acc+q both fit in W+1 bits
        dbl   = {acc_i[DATA_WIDTH-1:0], 1'b0};
        sum   = acc_i + (acc_i[0] ? q_ext : '0);
        acc_o = '0;
        if (dir_i == TO_MONT) begin
            acc_o = (dbl >= q_ext) ? (dbl - q_ext) : dbl;
        end else begin
            acc_o = sum >> 1;
        end
    end

endmodule

// File: rtl/mont_converter.sv
// Converts an operand into or out of Montgomery form (R = 2^LOG_R) over LOG_R
// serial iterations, with valid/ready handshakes on both sides.
//
//   state | meaning
//   IDLE  | ready_o high, waiting for valid_i
//   RUN   | iterating, counter counts 0 .. LOG_R-1
//   DONE  | valid_o high, result held until ready_i
module mont_converter
    import otbn_pq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG_R      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  dir_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int CNT_W = $clog2(LOG_R + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOG_R - 1);

    conv_state_e           state_q, state_d;
    conv_dir_e             dir_q, dir_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [DATA_WIDTH:0]   acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH:0]   acc_step;
    logic [DATA_WIDTH:0]   q_ext;

    mont_conv_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .dir_i(dir_q),
        .acc_i(acc_q),
        .q_i  (q_q),
        .acc_o(acc_step)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dir_q   <= TO_MONT;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        q_ext   = {1'b0, q_q};
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = RUN;
                    dir_d   = conv_dir_e'(dir_i);
                    q_d     = q_i;
                    acc_d   = {1'b0, a_i};
                    cnt_d   = '0;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Final correction guarantees a fully reduced result
                    if (acc_step >= q_ext) begin
                        acc_d = acc_step - q_ext;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces IDLE asynchronously, so ready_o is gated to stay low during reset
    assign ready_o = (state_q == IDLE) && !rst_i;
    assign valid_o = (state_q == DONE);
    assign res_o   = valid_o ? acc_q[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_mont_converter.sv
// Directed and random round-trip checks for mont_converter (DATA_WIDTH = LOG_R = 32).
module tb_mont_converter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        dir_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] q_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] res_o;

    int tests = 0;
    int fails = 0;

    mont_converter #(
        .DATA_WIDTH(32),
        .LOG_R     (32)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .dir_i  (dir_i),
        .a_i    (a_i),
        .q_i    (q_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .res_o  (res_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_op(input string tag, input logic d, input logic [31:0] a, input logic [31:0] q);
        int n;
        n = 0;
        while (!ready_o && n < 200) begin
            tick();
            n++;
        end
        check({tag, " ready"}, ready_o, 1);
        dir_i   = d;
        a_i     = a;
        q_i     = q;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        // Scramble inputs after acceptance; captured copies must be used
        dir_i   = ~d;
        a_i     = $urandom;
        q_i     = $urandom;
    endtask

    task automatic wait_result(input string tag, output logic [31:0] res);
        int n;
        n = 0;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 32);
        res = res_o;
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic d, input logic [31:0] a, input logic [31:0] q,
                          output logic [31:0] res);
        start_op(tag, d, a, q);
        wait_result(tag, res);
        release_result();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] q;
        logic [31:0] a;
        logic [63:0] fwd_exp;
        int          seen_valid;

        // Reset state
        #1;
        check("rst ready", ready_o, 0);
        check("rst valid", valid_o, 0);
        check("rst res", res_o, 0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check("post-rst ready", ready_o, 1);
        check("idle res", res_o, 0);

        // Known Kyber-modulus vectors: 2^32 mod 3329 = 1353
        run_op("to 1", 1'b0, 32'd1, 32'd3329, r);
        check("to 1 res", r, 1353);
        run_op("from 1353", 1'b1, 32'd1353, 32'd3329, r);
        check("from 1353 res", r, 1);
        run_op("to 3328", 1'b0, 32'd3328, 32'd3329, r);
        check("to 3328 res", r, 1976);
        run_op("from 0", 1'b1, 32'd0, 32'd3329, r);
        check("from 0 res", r, 0);
        run_op("to 0", 1'b0, 32'd0, 32'd3329, r);
        check("to 0 res", r, 0);

        // Back-pressure in DONE: result held, new requests ignored
        start_op("hold", 1'b0, 32'd1, 32'd3329);
        wait_result("hold", r);
        check("hold res", r, 1353);
        valid_i = 1'b1;
        dir_i   = 1'b1;
        a_i     = 32'd77;
        q_i     = 32'd3329;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold valid", valid_o, 1);
            check("hold data", res_o, 1353);
            check("hold ready", ready_o, 0);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        valid_i = 1'b0;
        check("release valid", valid_o, 0);
        check("release res", res_o, 0);
        check("release ready", ready_o, 1);
        tick();
        check("no accept on release", ready_o, 1);

        // Reset in the middle of RUN
        start_op("abort", 1'b0, 32'd1, 32'd3329);
        for (int i = 0; i < 15; i++) tick();
        check("mid-run ready", ready_o, 0);
        rst_i = 1'b1;
        #1;
        check("abort ready", ready_o, 0);
        check("abort valid", valid_o, 0);
        check("abort res", res_o, 0);
        tick();
        tick();
        check("abort held valid", valid_o, 0);
        rst_i = 1'b0;
        tick();
        check("abort post ready", ready_o, 1);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_o) seen_valid++;
        end
        check("abort no result", seen_valid, 0);
        run_op("after abort", 1'b0, 32'd1, 32'd3329, r);
        check("after abort res", r, 1353);

        // Random round trips with an independent 64-bit model for the forward leg
        for (int i = 0; i < 1000; i++) begin
            q = ($urandom & 32'h7FFF_FFFF) | 32'd1;
            if (q < 32'd3) q = 32'd3;
            a = $urandom % q;
            fwd_exp = ({32'd0, a} << 32) % {32'd0, q};
            run_op("rt fwd", 1'b0, a, q, r);
            check("rt fwd res", r, fwd_exp);
            run_op("rt back", 1'b1, r, q, r);
            check("rt back res", r, a);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mont_converter.md
MONT_CONVERTER -- requirements
Module: mont_converter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of operands, modulus and result.
REQ-002 SHALL have parameter LOG_R, default 32: Montgomery radix exponent, R = 2^LOG_R.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports as below, clock and reset first.
REQ-004 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-006 SHALL have port valid_i  input  1  request present.
REQ-007 SHALL have port ready_o  output  1  converter can accept a request.
REQ-008 SHALL have port dir_i  input  1  0 = to Montgomery form (a*R mod q), 1 = from Montgomery form (a*R^-1 mod q).
REQ-009 SHALL have port a_i  input  DATA_WIDTH  operand, required a_i < q_i.
REQ-010 SHALL have port q_i  input  DATA_WIDTH  modulus, required odd, q_i < 2^(DATA_WIDTH-1).
REQ-011 SHALL have port valid_o  output  1  result available.
REQ-012 SHALL have port ready_i  input  1  consumer accepts result.
REQ-013 SHALL have port res_o  output  DATA_WIDTH  result, fully reduced, 0 <= res_o < q.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 SHALL assert ready_o only in IDLE; request accepted on a rising edge with valid_i && ready_o.
REQ-016 SHALL, on acceptance, capture dir_i, a_i, q_i into internal registers; later changes on those inputs SHALL NOT affect the operation.
REQ-017 SHALL load accumulator acc (DATA_WIDTH+1 bits) with a_i and iteration counter with 0 on acceptance, entering RUN.
REQ-018 SHALL, in RUN with dir=0, per edge: acc = 2*acc; if acc >= q then acc = acc - q.
REQ-019 SHALL, in RUN with dir=1, per edge: if acc odd then acc = acc + q; acc = acc >> 1.
REQ-020 SHALL perform exactly LOG_R iterations; on the LOG_R-th RUN edge apply final correction (if acc >= q, acc = acc - q) and enter DONE.
REQ-021 SHALL assert valid_o only in DONE, valid_o high from the cycle after the LOG_R-th rising edge following acceptance (latency LOG_R cycles).
REQ-022 SHALL hold res_o and valid_o stable in DONE while ready_i is low.
REQ-023 SHALL return to IDLE on an edge with valid_o && ready_i; a new request SHALL NOT be accepted on that same edge (one idle cycle minimum between results).
REQ-024 SHALL drive res_o = 0 whenever valid_o is low.
REQ-025 SHALL never overflow acc: DATA_WIDTH+1 bits suffice given REQ-010.
REQ-026 SHALL complete in LOG_R cycles regardless of operand values; with even q result is unspecified but timing unchanged.

Reset
REQ-027 SHALL, on rst_i high (asynchronous, any state incl. mid-RUN), force IDLE, acc = 0, counter = 0, captured registers = 0.
REQ-028 SHALL hold ready_o = 0, valid_o = 0, res_o = 0 while rst_i is high; ready_o = 1 first cycle after release.
REQ-029 SHALL discard any in-flight operation on reset; no result emitted for it.

Structure
REQ-030 SHALL place FSM state enum (IDLE, RUN, DONE) and direction enum (TO_MONT = 0, FROM_MONT = 1) in shared package otbn_pq_pkg.
REQ-031 SHALL isolate one combinational iteration (REQ-018/REQ-019 selected by dir) in sub-module mont_conv_step; FSM, counter and handshake stay in mont_converter.

Verification
REQ-032 SHALL verify: q=3329, dir=0, a=1 -> res_o=1353 exactly 32 cycles after acceptance.
REQ-033 SHALL verify: q=3329, dir=1, a=1353 -> res_o=1; dir=0, a=3328 -> res_o=1976.
REQ-034 SHALL verify: q=3329, dir=1, a=0 -> res_o=0; dir=0, a=0 -> res_o=0.
REQ-035 SHALL verify: ready_i held low 10 cycles in DONE -> res_o, valid_o stable, ready_o=0, new valid_i ignored.
REQ-036 SHALL verify: rst_i pulsed at RUN iteration 15 -> outputs zero immediately, ready_o=1 after release, next request (q=3329, dir=0, a=1) yields 1353.
REQ-037 SHALL verify: 1000 random (a<q, odd q<2^31, dir) round trips to-then-from return original a.
